// File: rtl/alu_8bit.sv
`default_nettype none
// ============================================================================
// Module   : alu_8bit
// Purpose  : Registered 8-bit ALU. Eight operations selected by func are
//            computed combinationally from the unregistered operands and the
//            result is captured on the rising clock edge (1-cycle latency).
//            Optional flags (carry/zero/neg) are built when the macro
//            ALU_FLAGS_EN is defined; without it the flag ports are absent.
// Revision : 1.0  initial release
// ============================================================================
module alu_8bit (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [2:0] func,
  input  logic       clk,
  output logic [7:0] out,
  input  logic       rst_n
`ifdef ALU_FLAGS_EN
  ,
  output logic       carry,
  output logic       zero,
  output logic       neg
`endif
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_PASS = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  logic [7:0] result;

  // Select the next result; arithmetic wraps modulo 256, no saturation.
  always_comb begin
    result = 8'h00;
    case (func)
      OP_ADD:  result = in1 + in2;
      OP_SUB:  result = in1 - in2;
      OP_PASS: result = in1;
      OP_SHL:  result = {in1[6:0], 1'b0};
      OP_SHR:  result = {1'b0, in1[7:1]};
      OP_AND:  result = in1 & in2;
      OP_NOT:  result = ~in1;
      OP_OR:   result = in1 | in2;
      default: result = 8'h00;
    endcase
  end

  // Capture the result each edge; reset clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 8'h00;
    end else begin
      out <= result;
    end
  end

`ifdef ALU_FLAGS_EN
  logic carry_next;

  // Carry is the bit pushed out of the 8-bit result; SUB reports a borrow.
  always_comb begin
    carry_next = 1'b0;
    case (func)
      OP_ADD:  carry_next = (({1'b0, in1} + {1'b0, in2}) > 9'd255);
      OP_SUB:  carry_next = (in1 < in2);
      OP_SHL:  carry_next = in1[7];
      OP_SHR:  carry_next = in1[0];
      default: carry_next = 1'b0;
    endcase
  end

  // Flags are registered alongside out so they line up with the same result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
    end else begin
      carry <= carry_next;
      zero  <= (result == 8'h00);
      neg   <= result[7];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_8bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_8bit
// Purpose  : Directed self-checking bench for alu_8bit. Flag checks are
//            compiled in only when ALU_FLAGS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_8bit;

  logic [7:0] in1;
  logic [7:0] in2;
  logic [2:0] func;
  logic       clk;
  logic [7:0] out;
  logic       rst_n;
`ifdef ALU_FLAGS_EN
  logic       carry;
  logic       zero;
  logic       neg;
`endif

  int checks = 0;
  int errors = 0;

  alu_8bit dut (
    .in1   (in1),
    .in2   (in2),
    .func  (func),
    .clk   (clk),
    .out   (out),
    .rst_n (rst_n)
`ifdef ALU_FLAGS_EN
    ,
    .carry (carry),
    .zero  (zero),
    .neg   (neg)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a vector at the falling edge, then wait until just after the
  // rising edge that captures it.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    @(negedge clk);
    in1  = a;
    in2  = b;
    func = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Assert reset before any clock edge: out must clear with no edge.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: out=%h expected=00", out);
    end
    // Hold reset across edges with busy inputs.
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 8'h01, 3'b000);
      checks++;
      if (out !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out=%h expected=00", i, out);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({carry, zero, neg} !== 3'b000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: flags=%b expected=000", i, {carry, zero, neg});
      end
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd1, 8'd2, 3'b000);
    checks++;
    if (out !== 8'd3) begin
      errors++;
      $display("FAIL reset_release_add: out=%0d expected=3", out);
    end
  endtask

  task automatic test_arith();
    drive(8'd5, 8'd1, 3'b001);
    checks++;
    if (out !== 8'd4) begin errors++; $display("FAIL sub_5_1: out=%0d expected=4", out); end
    drive(8'd10, 8'd236, 3'b001);
    checks++;
    if (out !== 8'd30) begin errors++; $display("FAIL sub_10_neg20: out=%0d expected=30", out); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (carry !== 1'b1) begin errors++; $display("FAIL sub_borrow: carry=%b expected=1", carry); end
`endif
    drive(8'd0, 8'd42, 3'b000);
    checks++;
    if (out !== 8'd42) begin errors++; $display("FAIL add_0_42: out=%0d expected=42", out); end
    drive(8'd200, 8'd100, 3'b000);
    checks++;
    if (out !== 8'd44) begin errors++; $display("FAIL add_200_100: out=%0d expected=44", out); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (carry !== 1'b1) begin errors++; $display("FAIL add_carry: carry=%b expected=1", carry); end
`endif
  endtask

  task automatic test_shift_pass();
    drive(8'd12, 8'd99, 3'b010);
    checks++;
    if (out !== 8'd12) begin errors++; $display("FAIL pass_12: out=%0d expected=12", out); end
    drive(8'd9, 8'd0, 3'b011);
    checks++;
    if (out !== 8'd18) begin errors++; $display("FAIL shl_9: out=%0d expected=18", out); end
    drive(8'd6, 8'd0, 3'b100);
    checks++;
    if (out !== 8'd3) begin errors++; $display("FAIL shr_6: out=%0d expected=3", out); end
    drive(8'd0, 8'd0, 3'b011);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL shl_0: out=%0d expected=0", out); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL shl_0_zero: zero=%b expected=1", zero); end
`endif
    drive(8'd0, 8'd0, 3'b100);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL shr_0: out=%0d expected=0", out); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL shr_0_zero: zero=%b expected=1", zero); end
`endif
    drive(8'h80, 8'd0, 3'b011);
    checks++;
    if (out !== 8'h00) begin errors++; $display("FAIL shl_msb_drop: out=%h expected=00", out); end
    drive(8'h01, 8'd0, 3'b100);
    checks++;
    if (out !== 8'h00) begin errors++; $display("FAIL shr_lsb_drop: out=%h expected=00", out); end
  endtask

  task automatic test_logic();
    drive(8'd23, 8'd62, 3'b101);
    checks++;
    if (out !== 8'd22) begin errors++; $display("FAIL and_23_62: out=%0d expected=22", out); end
    drive(8'd50, 8'd7, 3'b110);
    checks++;
    if (out !== 8'd205) begin errors++; $display("FAIL not_50: out=%0d expected=205", out); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (neg !== 1'b1) begin errors++; $display("FAIL not_50_neg: neg=%b expected=1", neg); end
`endif
    drive(8'd23, 8'd4, 3'b111);
    checks++;
    if (out !== 8'd23) begin errors++; $display("FAIL or_23_4: out=%0d expected=23", out); end
    drive(8'd0, 8'd12, 3'b101);
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL and_0_12: out=%0d expected=0", out); end
    drive(8'd0, 8'd0, 3'b110);
    checks++;
    if (out !== 8'd255) begin errors++; $display("FAIL not_0: out=%0d expected=255", out); end
    drive(8'd11, 8'd0, 3'b111);
    checks++;
    if (out !== 8'd11) begin errors++; $display("FAIL or_11_0: out=%0d expected=11", out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [8] = '{8'd3, 8'd20, 8'd77, 8'h81, 8'h81, 8'hF0, 8'h0F, 8'hA0};
    logic [7:0] vb [8] = '{8'd4, 8'd5,  8'd1,  8'h00, 8'h00, 8'h3C, 8'h00, 8'h05};
    logic [2:0] vf [8] = '{3'd0, 3'd1,  3'd2,  3'd3,  3'd4,  3'd5,  3'd6,  3'd7};
    logic [7:0] ve [8] = '{8'd7, 8'd15, 8'd77, 8'h02, 8'h40, 8'h30, 8'hF0, 8'hA5};
`ifdef ALU_FLAGS_EN
    logic       vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       vn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    // One new vector per cycle: each result must appear on the very next edge.
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], vf[i]);
      checks++;
      if (out !== ve[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: out=%h expected=%h", i, out, ve[i]);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({carry, zero, neg} !== {vc[i], 1'b0, vn[i]}) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: flags=%b expected=%b", i, {carry, zero, neg}, {vc[i], 1'b0, vn[i]});
      end
`endif
    end
    // Inputs changing between edges: out holds, and only the final value counts.
    @(negedge clk);
    in1 = 8'd1; in2 = 8'd1; func = 3'b000;
    #2;
    in1 = 8'h11; in2 = 8'h22; func = 3'b111;
    #1;
    checks++;
    if (out !== 8'hA5) begin errors++; $display("FAIL hold_between_edges: out=%h expected=a5", out); end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 8'h33) begin errors++; $display("FAIL last_value_wins: out=%h expected=33", out); end
  endtask

  task automatic test_midstream_reset();
    drive(8'd50, 8'd50, 3'b000);
    checks++;
    if (out !== 8'd100) begin errors++; $display("FAIL pre_reset_add: out=%0d expected=100", out); end
    @(negedge clk);
    in1 = 8'd9; in2 = 8'd1; func = 3'b001;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL midstream_reset_async: out=%0d expected=0", out); end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL midstream_reset_hold: out=%0d expected=0", out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 8'd8) begin errors++; $display("FAIL post_reset_first_edge: out=%0d expected=8", out); end
  endtask

  initial begin
    rst_n = 1'b1;
    in1   = 8'h5A;
    in2   = 8'h33;
    func  = 3'b000;
    test_reset();
    test_arith();
    test_shift_pass();
    test_logic();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
